// File: rtl/fp_add_arbiter_if.sv
// fp_add_arbiter_if: bundle between the datapath clients, the fp_add core and the arbiter.
//   req/req_a/req_b : per-requester request level and operands (32 bits per requester)
//   gnt             : one-hot combinational grant back to the requesters
//   add_areset      : active-high reset to the fp_add core
//   add_a/add_b     : registered operands to the core; add_q: sum from the core
//   rsp_valid/id/q  : result strobe, originating requester and sum
//   busy            : any request pending or any operation in flight
//   stat_clr        : synchronous clear of the issue counters; stat_cnt: 16 bits per requester
// Modport slave is the arbiter side; master is the client/core side.
interface fp_add_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]      req;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic [NREQ-1:0]      gnt;
   logic                 add_areset;
   logic [31:0]          add_a;
   logic [31:0]          add_b;
   logic [31:0]          add_q;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_q;
   logic                 busy;
   logic                 stat_clr;
   logic [16*NREQ-1:0]   stat_cnt;

   modport slave (
      input  req, req_a, req_b, add_q, stat_clr,
      output gnt, add_areset, add_a, add_b, rsp_valid, rsp_id, rsp_q, busy, stat_cnt
   );

   modport master (
      output req, req_a, req_b, add_q, stat_clr,
      input  gnt, add_areset, add_a, add_b, rsp_valid, rsp_id, rsp_q, busy, stat_cnt
   );
endinterface

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin scheduler sharing one pipelined fp_add core between NREQ
// requesters. At most one grant per cycle; the granted operands are registered into the
// core and a {valid, id} tag pipeline tracks each operation so the sum returns with the
// id of the requester that issued it.
// Ports:
//   clk      : clock, rising edge
//   areset_n : asynchronous active-low reset
//   bus      : fp_add_arbiter_if.slave (requests, grant, core operands/result, response,
//              busy, statistics)
// Optional feature: define FP_ARB_STATS_EN to build the per-requester saturating issue
// counters; without it stat_cnt is tied to zero and stat_clr is ignored.
module fp_add_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 7,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic          clk,
   input  logic          areset_n,
   fp_add_arbiter_if.slave bus
);

   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [31:0]             add_a_q, add_a_d;
   logic [31:0]             add_b_q, add_b_d;
   // Stage 0 is loaded on the issue edge alongside add_a/add_b; stages 1..LAT follow the
   // core latency, so the last stage lines up with add_q.
   logic [LAT:0]            tag_vld_q, tag_vld_d;
   logic [LAT:0][IDW-1:0]   tag_id_q, tag_id_d;

   logic [NREQ-1:0]         gnt;
   logic                    gnt_any;
   logic [IDW-1:0]          gnt_id;
   logic [IDW-1:0]          cand;

   // Rotating priority search starting at ptr_q.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = IDW'((32'(ptr_q) + off) % NREQ);
         if (!gnt_any && bus.req[cand]) begin
            gnt_any   = 1'b1;
            gnt_id    = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d   = ptr_q;
      add_a_d = add_a_q;
      add_b_d = add_b_q;
      if (gnt_any) begin
         ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
         add_a_d = bus.req_a[32*gnt_id +: 32];
         add_b_d = bus.req_b[32*gnt_id +: 32];
      end
      tag_vld_d = {tag_vld_q[LAT-1:0], gnt_any};
      tag_id_d  = {tag_id_q[LAT-1:0], gnt_id};
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         ptr_q     <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         ptr_q     <= ptr_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   assign bus.gnt        = gnt;
   assign bus.add_areset = ~areset_n;
   assign bus.add_a      = add_a_q;
   assign bus.add_b      = add_b_q;
   assign bus.rsp_valid  = tag_vld_q[LAT];
   assign bus.rsp_id     = tag_id_q[LAT];
   assign bus.rsp_q      = bus.add_q;
   assign bus.busy       = (|bus.req) | (|tag_vld_q);

`ifdef FP_ARB_STATS_EN
   logic [NREQ-1:0][15:0] stat_q, stat_d;

   // Clear wins over a same-edge grant; counters stick at 16'hFFFF.
   always_comb begin
      stat_d = stat_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (bus.stat_clr) begin
            stat_d[i] = '0;
         end else if (gnt[i] && (stat_q[i] != 16'hFFFF)) begin
            stat_d[i] = stat_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign bus.stat_cnt = stat_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = bus.stat_clr;
   assign bus.stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: self-checking bench for fp_add_arbiter with a behavioural fp_add core
// (LAT-cycle pipeline), a round-robin reference for the grant, and a scoreboard of
// {id, sum, due cycle} entries pushed at each grant and popped at each response.
module tb_fp_add_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned LAT  = 7;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] q;
      int          due;
   } sb_t;

   logic clk;
   logic areset_n;

   fp_add_arbiter_if #(.NREQ(NREQ)) bus ();

   fp_add_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .bus      (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rsp_cnt = 0;
   int          exp_ptr = 0;
   logic [31:0] last_q;
   logic [1:0]  last_id;
   sb_t         sb[$];
   int          gnt_log[$];
   logic [3:0]  eg;
   int          k;
   sb_t         e;
   logic [31:0] core_pipe [LAT];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Single-precision to double for normal numbers and zero.
   function automatic real sp2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) d = {x[31], 63'd0};
      else d = {x[31], 11'({3'd0, x[30:23]}) + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Truncating double to single; exact for the operand pairs used here.
   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] ex;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      ex = d[62:52] - 11'd896;
      return {d[63], ex[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
      return r2sp(sp2r(a) + sp2r(b));
   endfunction

   // Behavioural fp_add core: sum appears LAT cycles after add_a/add_b change.
   always @(posedge clk or posedge bus.add_areset) begin
      if (bus.add_areset) begin
         for (int i = 0; i < LAT; i++) core_pipe[i] <= '0;
      end else begin
         core_pipe[0] <= sp_add(bus.add_a, bus.add_b);
         for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
      end
   end
   assign bus.add_q = core_pipe[LAT-1];

   // Monitor: mid-cycle, inputs are stable (driven 1 time unit after posedge).
   always @(negedge clk) begin
      if (!areset_n) begin
         sb.delete();
         exp_ptr = 0;
         check("rst_add_areset", 64'(bus.add_areset), 64'd1);
         check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      end else begin
         eg = '0;
         for (int off = 0; off < NREQ; off++) begin
            if (eg == '0 && bus.req[(exp_ptr + off) % NREQ]) eg[(exp_ptr + off) % NREQ] = 1'b1;
         end
         check("gnt", 64'(bus.gnt), 64'(eg));
         if (bus.rsp_valid) begin
            rsp_cnt++;
            last_q  = bus.rsp_q;
            last_id = bus.rsp_id;
            if (sb.size() == 0) begin
               check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
               check("rsp_q", 64'(bus.rsp_q), 64'(e.q));
               check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
         end
         if (|(bus.req & bus.gnt)) begin
            k = 0;
            for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) k = i;
            sb.push_back('{id: 2'(k),
                           q: sp_add(bus.req_a[32*k +: 32], bus.req_b[32*k +: 32]),
                           due: cyc + 1 + LAT});
            gnt_log.push_back(k);
            exp_ptr = (k + 1) % NREQ;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      bus.req_a[32*i +: 32] = a;
      bus.req_b[32*i +: 32] = b;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && bus.busy; i++) tick();
      check("drain_busy", 64'(bus.busy), 64'd0);
      check("drain_sb_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_stat1(input string tag, input logic [15:0] exp_on);
`ifdef FP_ARB_STATS_EN
      check(tag, 64'(bus.stat_cnt[31:16]), 64'(exp_on));
`else
      check(tag, 64'(bus.stat_cnt[31:16]), 64'd0);
`endif
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int r0;

   initial begin
      areset_n     = 1'b0;
      bus.req      = '0;
      bus.req_a    = '0;
      bus.req_b    = '0;
      bus.stat_clr = 1'b0;
      repeat (2) tick();
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_add_a", 64'(bus.add_a), 64'd0);
      check("rst_add_b", 64'(bus.add_b), 64'd0);
      check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      check("rst_busy_idle", 64'(bus.busy), 64'd0);
      check("rst_stat_cnt", 64'(bus.stat_cnt), 64'd0);
      check("rst_add_areset_hi", 64'(bus.add_areset), 64'd1);
      bus.req = 4'b0100;
      #1;
      check("rst_busy_req", 64'(bus.busy), 64'd1);
      bus.req = '0;
      areset_n = 1'b1;
      tick();
      check("add_areset_lo", 64'(bus.add_areset), 64'd0);

      // Single requester, one-cycle pulse.
      r0 = rsp_cnt;
      set_op(0, 32'h3fe8a090, 32'h3f800000);
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
      check("t1_add_a", 64'(bus.add_a), 64'h3fe8a090);
      check("t1_add_b", 64'(bus.add_b), 64'h3f800000);
      drain();
      check("t1_rsp_count", 64'(rsp_cnt - r0), 64'd1);
      check("t1_rsp_id", 64'(last_id), 64'd0);

      // Wrap and fairness: grant 3 alone, then 4'b1001 gives 0 then 3.
      gnt_log.delete();
      set_op(3, 32'h40000000, 32'h3f800000);
      bus.req = 4'b1000;
      tick();
      bus.req = 4'b1001;
      repeat (2) tick();
      bus.req = '0;
      drain();
      check("wrap_n", 64'(gnt_log.size()), 64'd3);
      if (gnt_log.size() == 3) begin
         check("wrap_g0", 64'(gnt_log[0]), 64'd3);
         check("wrap_g1", 64'(gnt_log[1]), 64'd0);
         check("wrap_g2", 64'(gnt_log[2]), 64'd3);
      end

      // All four requesting continuously from ptr 0.
      gnt_log.delete();
      for (int i = 0; i < NREQ; i++) set_op(i, 32'h3f800000, 32'h3f000000);
      bus.req = 4'b1111;
      repeat (8) tick();
      bus.req = '0;
      drain();
      check("rr_n", 64'(gnt_log.size()), 64'd8);
      for (int i = 0; i < gnt_log.size(); i++) check("rr_order", 64'(gnt_log[i]), 64'(i % 4));
      check("rr_rsp_q", 64'(last_q), 64'h3fc00000);

      // Sign handling on requester 2.
      set_op(2, 32'h3f000000, 32'hbe800000);
      bus.req = 4'b0100;
      tick();
      bus.req = '0;
      drain();
      check("sign_rsp_q", 64'(last_q), 64'h3e800000);
      check("sign_rsp_id", 64'(last_id), 64'd2);

      // ptr at 2 with all requesting: 2, 3, 0, 1.
      bus.req = 4'b0010;
      tick();
      gnt_log.delete();
      bus.req = 4'b1111;
      repeat (4) tick();
      bus.req = '0;
      drain();
      check("rot_n", 64'(gnt_log.size()), 64'd4);
      if (gnt_log.size() == 4) begin
         check("rot_g0", 64'(gnt_log[0]), 64'd2);
         check("rot_g1", 64'(gnt_log[1]), 64'd3);
         check("rot_g2", 64'(gnt_log[2]), 64'd0);
         check("rot_g3", 64'(gnt_log[3]), 64'd1);
      end

      // Reset with three operations in flight.
      bus.req = 4'b1111;
      repeat (3) tick();
      bus.req = '0;
      tick();
      areset_n = 1'b0;
      #1;
      check("mid_add_areset", 64'(bus.add_areset), 64'd1);
      repeat (2) tick();
      areset_n = 1'b1;
      r0 = rsp_cnt;
      repeat (LAT + 4) tick();
      check("mid_no_rsp", 64'(rsp_cnt - r0), 64'd0);
      gnt_log.delete();
      bus.req = 4'b1111;
      tick();
      bus.req = '0;
      check("mid_ptr0", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd0);
      drain();

      // Statistics on requester 1.
      bus.stat_clr = 1'b1;
      tick();
      bus.stat_clr = 1'b0;
      bus.req = 4'b0010;
      repeat (5) tick();
      bus.req = '0;
      check_stat1("stat_five", 16'd5);
      bus.stat_clr = 1'b1;
      tick();
      bus.stat_clr = 1'b0;
      check_stat1("stat_clr", 16'd0);
      bus.req = 4'b0010;
      bus.stat_clr = 1'b1;
      tick();
      bus.stat_clr = 1'b0;
      bus.req = '0;
      check_stat1("stat_clr_vs_gnt", 16'd0);
`ifdef FP_ARB_STATS_EN
      bus.req = 4'b0010;
      repeat (65534) tick();
      bus.req = '0;
      check_stat1("stat_preload", 16'hfffe);
      bus.req = 4'b0010;
      repeat (3) tick();
      bus.req = '0;
      check_stat1("stat_saturate", 16'hffff);
`endif
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
